// File: rtl/mdu_iter_if.sv
// Request/response bundle between the execute-stage operand forwarding and the
// iterative multiply/divide unit.
interface mdu_iter_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            is_word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, is_word, a, b, flush, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, is_word, a, b, flush, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit (shift-add multiply, restoring divide).
// Define MDU_FAST_MUL_EN to compute multiplies in a single cycle at accept.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// BUSY  | one multiply/divide step per cycle, cnt counts N-1 down to 0
// DONE  | result valid, held until out_ready
module mdu_iter #(
  parameter int XLEN = 64
) (
  input  logic     clk,
  input  logic     resetn,
  mdu_iter_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] X_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] W_MIN = {{(XLEN-31){1'b1}}, 31'b0};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] opa;
  logic [XLEN-1:0]   shr;
  logic              mul_r, word_r, hi_r, rem_r, neg_r;

  logic            is_mul, div_sgn, sgn_a, sgn_b, neg_a, neg_b;
  logic            div_zero, div_ovf, res_neg;
  logic [XLEN-1:0] xa, xb, mag_a, mag_b, fast_res;

  logic [2*XLEN-1:0] acc_mul;
  logic [XLEN:0]     rem_sh, rem_nx;
  logic [XLEN-1:0]   quo_nx, q_fin, r_fin, div_res;

  function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] v, input logic w);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  function automatic logic [XLEN-1:0] mul_sel(input logic [2*XLEN-1:0] p, input logic neg,
                                              input logic hi, input logic w);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return wfix(hi ? s[2*XLEN-1:XLEN] : s[XLEN-1:0], w);
  endfunction

  // Operand conditioning for the request currently presented
  always_comb begin
    is_mul   = ~bus.op[2];
    div_sgn  = bus.op[2] & ~bus.op[0];
    sgn_a    = is_mul ? (~bus.is_word & (bus.op != 3'd3)) : div_sgn;
    sgn_b    = is_mul ? (~bus.is_word & ~bus.op[1]) : div_sgn;
    xa       = bus.is_word ? {{(XLEN-32){div_sgn & bus.a[31]}}, bus.a[31:0]} : bus.a;
    xb       = bus.is_word ? {{(XLEN-32){div_sgn & bus.b[31]}}, bus.b[31:0]} : bus.b;
    neg_a    = sgn_a & xa[XLEN-1];
    neg_b    = sgn_b & xb[XLEN-1];
    mag_a    = neg_a ? -xa : xa;
    mag_b    = neg_b ? -xb : xb;
    res_neg  = (is_mul | ~bus.op[1]) ? (neg_a ^ neg_b) : neg_a;
    div_zero = ~is_mul & (xb == '0);
    div_ovf  = div_sgn & (&xb) & (xa == (bus.is_word ? W_MIN : X_MIN));
    fast_res = div_zero ? (bus.op[1] ? xa : '1) : (bus.op[1] ? '0 : xa);
  end

  // One iteration step; the divide reuses acc as remainder and shr as quotient
  always_comb begin
    acc_mul = shr[0] ? acc + opa : acc;
    rem_sh  = {acc[XLEN-1:0], shr[XLEN-1]};
    rem_nx  = rem_sh;
    quo_nx  = {shr[XLEN-2:0], 1'b0};
    if (rem_sh >= {1'b0, opa[XLEN-1:0]}) begin
      rem_nx = rem_sh - {1'b0, opa[XLEN-1:0]};
      quo_nx = {shr[XLEN-2:0], 1'b1};
    end
    q_fin   = neg_r ? -quo_nx : quo_nx;
    r_fin   = neg_r ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
    div_res = wfix(rem_r ? r_fin : q_fin, word_r);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      shr    <= '0;
      mul_r  <= 1'b0;
      word_r <= 1'b0;
      hi_r   <= 1'b0;
      rem_r  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (bus.flush) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mul_r  <= is_mul;
            word_r <= bus.is_word;
            hi_r   <= ~bus.is_word & (bus.op[1:0] != 2'd0);
            rem_r  <= bus.op[1];
            neg_r  <= res_neg;
            acc    <= '0;
            bus.in_ready <= 1'b0;
            if (div_zero | div_ovf) begin
              bus.result    <= wfix(fast_res, bus.is_word);
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end
`ifdef MDU_FAST_MUL_EN
            else if (is_mul) begin
              bus.result    <= mul_sel({{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b}, res_neg,
                                       ~bus.is_word & (bus.op[1:0] != 2'd0), bus.is_word);
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end
`endif
            else begin
              cnt   <= bus.is_word ? CW'(31) : CW'(XLEN-1);
              state <= BUSY;
              if (is_mul) begin
                opa <= {{XLEN{1'b0}}, mag_a};
                shr <= mag_b;
              end else begin
                // W dividends are pre-aligned to the top so 32 steps consume them
                opa <= {{XLEN{1'b0}}, mag_b};
                shr <= bus.is_word ? (mag_a << (XLEN-32)) : mag_a;
              end
            end
          end
        end
        BUSY: begin
          if (mul_r) begin
            acc <= acc_mul;
            opa <= opa << 1;
            shr <= shr >> 1;
          end else begin
            acc <= {{(XLEN-1){1'b0}}, rem_nx};
            shr <= quo_nx;
          end
          if (cnt == '0) begin
            bus.result    <= mul_r ? mul_sel(acc_mul, neg_r, hi_r, word_r) : div_res;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus random ops against
// a plain-arithmetic RV64M model.
module tb_mdu_iter;
  localparam int XLEN = 64;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_iter_if #(.XLEN(XLEN)) bus();
  mdu_iter #(.XLEN(XLEN)) dut (.clk(clk), .resetn(resetn), .bus(bus));

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  function automatic logic [63:0] ext_op(input logic [63:0] v, input logic w, input logic sgn);
    return w ? (sgn ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]}) : v;
  endfunction

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic [63:0] x, y, q, r, res;
    logic signed [63:0] sx, sy;
    logic sgn;
    if (!op[2]) begin
      if (w) begin
        p = {96'b0, a[31:0]} * {96'b0, b[31:0]};
        return {{32{p[31]}}, p[31:0]};
      end
      ea = (op != 3'd3) ? {{64{a[63]}}, a} : {64'b0, a};
      eb = (op <= 3'd1) ? {{64{b[63]}}, b} : {64'b0, b};
      p = ea * eb;
      return (op == 3'd0) ? p[63:0] : p[127:64];
    end
    sgn = !op[0];
    x = ext_op(a, w, sgn);
    y = ext_op(b, w, sgn);
    if (y == 64'd0) begin
      q = '1; r = x;
    end else if (sgn && y == '1 && x == (w ? 64'hFFFF_FFFF_8000_0000 : MIN64)) begin
      q = x; r = 64'd0;
    end else if (sgn) begin
      sx = x; sy = y;
      q = sx / sy; r = sx % sy;
    end else begin
      q = x / y; r = x % y;
    end
    res = op[1] ? r : q;
    return w ? {{32{res[31]}}, res[31:0]} : res;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y;
    logic sgn;
    if (!op[2]) return FAST_MUL ? 1 : (w ? 33 : 65);
    sgn = !op[0];
    x = ext_op(a, w, sgn);
    y = ext_op(b, w, sgn);
    if (y == 64'd0) return 1;
    if (sgn && y == '1 && x == (w ? 64'hFFFF_FFFF_8000_0000 : MIN64)) return 1;
    return w ? 33 : 65;
  endfunction

  // Issues one request, scrambles the inputs after accept, waits for out_valid (bounded).
  // lat counts clock edges from the accept edge to the first cycle with out_valid high.
  task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output int lat);
    @(negedge clk);
    bus.op = op; bus.is_word = w; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.op = ~op; bus.a = ~a; bus.b = b + 64'd1; bus.is_word = ~w;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    res = bus.result;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [2:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] res, exp_r;
    int lat, exp_l;
    exp_r = ref_res(op, w, a, b);
    exp_l = ref_lat(op, w, a, b);
    do_op(op, w, a, b, res, lat);
    checks++;
    if (res !== exp_r) begin
      failures++;
      $display("FAIL %s result op=%0d w=%0b a=%h b=%h got=%h exp=%h", name, op, w, a, b, res, exp_r);
    end
    checks++;
    if (lat !== exp_l) begin
      failures++;
      $display("FAIL %s latency op=%0d w=%0b got=%0d exp=%0d", name, op, w, lat, exp_l);
    end
    drain();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.in_valid = 1'b0; bus.op = 3'd0; bus.is_word = 1'b0; bus.a = '0; bus.b = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 64'd0) begin
      failures++;
      $display("FAIL reset_state got in_ready=%b out_valid=%b result=%h exp 1 0 0",
               bus.in_ready, bus.out_valid, bus.result);
    end
    resetn = 1'b1;
    @(negedge clk);
    bus.op = 3'd4; bus.a = 64'd100; bus.b = 64'd3; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid_busy got in_ready=%b out_valid=%b result=%h exp 1 0 0",
               bus.in_ready, bus.out_valid, bus.result);
    end
    @(negedge clk);
    resetn = 1'b1;
    check_op("after_reset_div", 3'd4, 1'b0, 64'd100, 64'd7);
  endtask

  task automatic test_div();
    check_op("div_neg7_2", 3'd4, 1'b0, -64'sd7, 64'd2);
    check_op("rem_neg7_2", 3'd6, 1'b0, -64'sd7, 64'd2);
    check_op("divu_7_2", 3'd5, 1'b0, 64'd7, 64'd2);
    check_op("div_by_zero", 3'd4, 1'b0, 64'd5, 64'd0);
    check_op("rem_by_zero", 3'd6, 1'b0, 64'd5, 64'd0);
    check_op("div_ovf", 3'd4, 1'b0, MIN64, '1);
    check_op("rem_ovf", 3'd6, 1'b0, MIN64, '1);
    check_op("divuw_zero", 3'd5, 1'b1, 64'h1234_5678_8765_4321, 64'hFFFF_FFFF_0000_0000);
    check_op("divw_ovf", 3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF);
  endtask

  task automatic test_mul();
    check_op("mulh_m1_m1", 3'd1, 1'b0, '1, '1);
    check_op("mulhu_m1_m1", 3'd3, 1'b0, '1, '1);
    check_op("mulw_7fff_2", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2);
    check_op("mulhsu_m1_3", 3'd2, 1'b0, '1, 64'd3);
    check_op("mul_min_min", 3'd0, 1'b0, MIN64, MIN64);
  endtask

  task automatic test_hold();
    logic [63:0] res;
    int lat;
    do_op(3'd4, 1'b1, 64'h1_0000_0064, 64'd10, res, lat);
    checks++;
    if (res !== 64'd10 || lat !== 33) begin
      failures++;
      $display("FAIL divw_hold_first got result=%h lat=%0d exp result=a lat=33", res, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.result !== 64'd10 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL divw_hold cycle=%0d got result=%h out_valid=%b in_ready=%b exp a 1 0",
                 i, bus.result, bus.out_valid, bus.in_ready);
      end
    end
    drain();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL divw_drain got out_valid=%b in_ready=%b exp 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    bus.op = 3'd4; bus.is_word = 1'b0; bus.a = 64'd1000; bus.b = 64'd9; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy got in_ready=%b out_valid=%b exp 1 0", bus.in_ready, bus.out_valid);
    end
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL flush_no_result got out_valid_cycles=%0d exp 0", seen);
    end
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.op = 3'd5; bus.a = 64'd50; bus.b = 64'd5;
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_idle_accept got in_ready=%b exp 1", bus.in_ready);
    end
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL flush_idle_no_result got out_valid_cycles=%0d exp 0", seen);
    end
    check_op("after_flush", 3'd7, 1'b0, 64'd50, 64'd7);
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return MIN64;
      3: return 64'($urandom_range(0, 20));
      4: return {{32{1'b1}}, $urandom()};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic test_random();
    logic [2:0] op;
    logic w;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      if (op inside {3'd1, 3'd2, 3'd3}) w = 1'b0;
      check_op("random", op, w, rnd_operand(), rnd_operand());
    end
  endtask

  task automatic test_back_to_back();
    check_op("b2b_mulhu", 3'd3, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210);
    check_op("b2b_remuw", 3'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd5);
    check_op("b2b_remw", 3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd5);
  endtask

  initial begin
    test_reset();
    test_div();
    test_mul();
    test_hold();
    test_flush();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
